wb_pipe_reg: RTL and testbench

- Parametrised successor to the single-lane MEM/WB register.
- Carries LANES independent register-file write requests through DEPTH register stages toward writeback.
- Hold-on-stall and bubble-on-flush are separate controls; x0 writes and same-bundle destination conflicts are sanitised at capture.
- Provides combinational forwarding lookup over all in-flight stages, plus a retired-write counter for performance monitoring.

---
 rtl/wb_pipe_reg.sv | 144 ++++++++++++++
 tb/tb_wb_pipe_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: multi-lane, multi-stage writeback pipeline register.
// Carries LANES register-file write requests through DEPTH stages, sanitises
// x0 writes and same-bundle destination conflicts at capture, offers
// combinational forwarding over all in-flight stages, and counts retired writes.

// Per-lane capture sanitiser: a lane keeps its enable only if it targets a
// nonzero register and no higher-index enabled lane targets the same one.
module wb_pipe_lane_san #(
  parameter int ADDR_W = 5,
  parameter int LANES  = 2,
  parameter int LANE   = 0
) (
  input  logic [LANES*ADDR_W-1:0] addr_all_i,
  input  logic [LANES-1:0]        en_all_i,
  output logic                    en_o
);
  logic [ADDR_W-1:0] my_addr;
  assign my_addr = addr_all_i[LANE*ADDR_W +: ADDR_W];

  // Drop x0 writes and writes shadowed by a later lane in the same bundle.
  always_comb begin
    en_o = en_all_i[LANE] && (my_addr != '0);
    for (int m = LANE + 1; m < LANES; m++) begin
      if (en_all_i[m] && (addr_all_i[m*ADDR_W +: ADDR_W] == my_addr))
        en_o = 1'b0;
    end
  end
endmodule

module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 2,
  parameter int DEPTH  = 1,
  parameter int QPORTS = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [LANES*DATA_W-1:0]  rd_data_i,
  input  logic [LANES*ADDR_W-1:0]  rd_addr_i,
  input  logic [LANES-1:0]         rd_en_i,
  output logic [LANES*DATA_W-1:0]  rd_data_o,
  output logic [LANES*ADDR_W-1:0]  rd_addr_o,
  output logic [LANES-1:0]         rd_en_o,
  input  logic [QPORTS*ADDR_W-1:0] q_addr_i,
  output logic [QPORTS-1:0]        q_hit_o,
  output logic [QPORTS*DATA_W-1:0] q_data_o,
  output logic [CNT_W-1:0]         retire_cnt_o
);
  logic [DEPTH-1:0][LANES*DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][LANES*ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][LANES-1:0]        en_q,   en_d;
  logic [LANES-1:0]                   san_en;
  logic [CNT_W-1:0]                   cnt_q, cnt_d, pop;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_san
      wb_pipe_lane_san #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE(k)) u_san (
        .addr_all_i (rd_addr_i),
        .en_all_i   (rd_en_i),
        .en_o       (san_en[k])
      );
    end
  endgenerate

  // Stage next-state: flush beats stall beats advance; data/addr of disabled
  // lanes pass through untouched, only the enable is sanitised.
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    en_d   = en_q;
    if (flush_i) begin
      data_d = '0;
      addr_d = '0;
      en_d   = '0;
    end else if (!stall_i) begin
      data_d[0] = rd_data_i;
      addr_d[0] = rd_addr_i;
      en_d[0]   = san_en;
      for (int s = 1; s < DEPTH; s++) begin
        data_d[s] = data_q[s-1];
        addr_d[s] = addr_q[s-1];
        en_d[s]   = en_q[s-1];
      end
    end
  end

  // Stage registers; reset clears every stage regardless of flush/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      addr_q <= '0;
      en_q   <= '0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      en_q   <= en_d;
    end
  end

  assign rd_data_o = data_q[DEPTH-1];
  assign rd_addr_o = addr_q[DEPTH-1];
  assign rd_en_o   = en_q[DEPTH-1];

  // Retire count: the last stage leaves on any non-stalled or flushing edge.
  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++)
      pop = pop + CNT_W'(en_q[DEPTH-1][l]);
    cnt_d = cnt_q;
    if (!stall_i || flush_i)
      cnt_d = cnt_q + pop;
  end

  // Retired-write counter register, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retire_cnt_o = cnt_q;

  // Forwarding lookup: scan oldest stage / lowest lane first so the last
  // match written (youngest stage, highest lane) wins.
  always_comb begin
    q_hit_o  = '0;
    q_data_o = '0;
    for (int j = 0; j < QPORTS; j++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (en_q[s][l] && (q_addr_i[j*ADDR_W +: ADDR_W] != '0) &&
              (addr_q[s][l*ADDR_W +: ADDR_W] == q_addr_i[j*ADDR_W +: ADDR_W])) begin
            q_hit_o[j]                  = 1'b1;
            q_data_o[j*DATA_W +: DATA_W] = data_q[s][l*DATA_W +: DATA_W];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: a DEPTH=1 and a DEPTH=3 instance share stimulus.
module tb_wb_pipe_reg;
  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [63:0] rd_data;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_en;
  logic [9:0]  q_addr;

  logic [63:0] o1_data, o3_data, o1_qd, o3_qd;
  logic [9:0]  o1_addr, o3_addr;
  logic [1:0]  o1_en, o3_en, o1_hit, o3_hit;
  logic [31:0] o1_cnt, o3_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_pipe_reg #(.DEPTH(1)) d1 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .rd_data_i(rd_data), .rd_addr_i(rd_addr), .rd_en_i(rd_en),
    .rd_data_o(o1_data), .rd_addr_o(o1_addr), .rd_en_o(o1_en),
    .q_addr_i(q_addr), .q_hit_o(o1_hit), .q_data_o(o1_qd), .retire_cnt_o(o1_cnt)
  );

  wb_pipe_reg #(.DEPTH(3)) d3 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .rd_data_i(rd_data), .rd_addr_i(rd_addr), .rd_en_i(rd_en),
    .rd_data_o(o3_data), .rd_addr_o(o3_addr), .rd_en_o(o3_en),
    .q_addr_i(q_addr), .q_hit_o(o3_hit), .q_data_o(o3_qd), .retire_cnt_o(o3_cnt)
  );

  typedef struct {
    logic        stall, flush;
    logic [1:0]  en;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [4:0]  q0, q1;
    logic [1:0]  xen;
    logic [4:0]  xa0, xa1;
    logic [31:0] xd0, xd1;
    logic        xh0, xh1;
    logic [31:0] xq0, xq1;
    logic [31:0] xcnt;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    rd_en   = en;
    rd_addr = {a1, a0};
    rd_data = {d1, d0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            stl flu en     a0 a1 d0      d1      q0 q1 | xen    xa0 xa1 xd0     xd1     h0 h1 xq0     xq1     cnt
    vt[0]  = '{1'b0,1'b0,2'b11, 3, 7,32'h11, 32'h22, 3, 7, 2'b11, 3, 7,32'h11, 32'h22, 1'b1,1'b1,32'h11, 32'h22, 0};
    vt[1]  = '{1'b0,1'b0,2'b01, 0, 2,32'h33, 32'h44, 3, 0, 2'b00, 0, 2,32'h33, 32'h44, 1'b0,1'b0,32'h0,  32'h0,  2};
    vt[2]  = '{1'b0,1'b0,2'b11, 5, 5,32'hA,  32'hB,  5, 0, 2'b10, 5, 5,32'hA,  32'hB,  1'b1,1'b0,32'hB,  32'h0,  2};
    vt[3]  = '{1'b0,1'b0,2'b01, 4, 0,32'h55, 32'h0,  4, 5, 2'b01, 4, 0,32'h55, 32'h0,  1'b1,1'b0,32'h55, 32'h0,  3};
    vt[4]  = '{1'b1,1'b0,2'b11, 6, 8,32'h66, 32'h77, 4, 6, 2'b01, 4, 0,32'h55, 32'h0,  1'b1,1'b0,32'h55, 32'h0,  3};
    vt[5]  = '{1'b1,1'b0,2'b11, 6, 8,32'h67, 32'h78, 4, 6, 2'b01, 4, 0,32'h55, 32'h0,  1'b1,1'b0,32'h55, 32'h0,  3};
    vt[6]  = '{1'b1,1'b0,2'b10, 1, 9,32'h1,  32'h99, 4, 9, 2'b01, 4, 0,32'h55, 32'h0,  1'b1,1'b0,32'h55, 32'h0,  3};
    vt[7]  = '{1'b0,1'b0,2'b10, 1, 9,32'h1,  32'h99, 9, 4, 2'b10, 1, 9,32'h1,  32'h99, 1'b1,1'b0,32'h99, 32'h0,  4};
    vt[8]  = '{1'b0,1'b0,2'b11, 1, 2,32'hAA, 32'hBB, 1, 2, 2'b11, 1, 2,32'hAA, 32'hBB, 1'b1,1'b1,32'hAA, 32'hBB, 5};
    vt[9]  = '{1'b1,1'b1,2'b11, 3, 4,32'hCC, 32'hDD, 1, 3, 2'b00, 0, 0,32'h0,  32'h0,  1'b0,1'b0,32'h0,  32'h0,  7};
    vt[10] = '{1'b0,1'b0,2'b01, 5, 5,32'hE,  32'hF,  5, 0, 2'b01, 5, 5,32'hE,  32'hF,  1'b1,1'b0,32'hE,  32'h0,  7};
    vt[11] = '{1'b1,1'b0,2'b00, 0, 0,32'h0,  32'h0,  5, 0, 2'b01, 5, 5,32'hE,  32'hF,  1'b1,1'b0,32'hE,  32'h0,  7};
    vt[12] = '{1'b0,1'b1,2'b11, 1, 2,32'h1,  32'h2,  5, 1, 2'b00, 0, 0,32'h0,  32'h0,  1'b0,1'b0,32'h0,  32'h0,  8};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    q_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_en",   {62'd0, o1_en}, 64'd0);
    chk("reset_data", o1_data, 64'd0);
    chk("reset_addr", {54'd0, o1_addr}, 64'd0);
    chk("reset_cnt",  {32'd0, o1_cnt}, 64'd0);
    chk("reset_hit",  {62'd0, o1_hit}, 64'd0);

    // DEPTH=1 table: inputs applied before the edge, outputs checked after it.
    for (int i = 0; i < 13; i++) begin
      stall = vt[i].stall;
      flush = vt[i].flush;
      drive(vt[i].en, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
      q_addr = {vt[i].q1, vt[i].q0};
      tick();
      chk($sformatf("v%0d_en", i),    {62'd0, o1_en}, {62'd0, vt[i].xen});
      chk($sformatf("v%0d_addr", i),  {54'd0, o1_addr}, {54'd0, vt[i].xa1, vt[i].xa0});
      chk($sformatf("v%0d_data", i),  o1_data, {vt[i].xd1, vt[i].xd0});
      chk($sformatf("v%0d_hit", i),   {62'd0, o1_hit}, {62'd0, vt[i].xh1, vt[i].xh0});
      chk($sformatf("v%0d_qdata", i), o1_qd, {vt[i].xq1, vt[i].xq0});
      chk($sformatf("v%0d_cnt", i),   {32'd0, o1_cnt}, {32'd0, vt[i].xcnt});
    end

    // Clean both instances before the DEPTH=3 sequences.
    stall = 1'b0; flush = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    q_addr = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("d3_reset_cnt", {32'd0, o3_cnt}, 64'd0);

    // Same destination written on consecutive cycles: youngest stage wins.
    q_addr = {5'd0, 5'd9};
    drive(2'b01, 9, 0, 32'h1, 0); tick();
    chk("d3_t0_hit",  {62'd0, o3_hit}, 64'd1);
    chk("d3_t0_qd",   o3_qd, 64'h1);
    chk("d3_t0_en",   {62'd0, o3_en}, 64'd0);
    drive(2'b01, 9, 0, 32'h2, 0); tick();
    chk("d3_t1_qd",   o3_qd, 64'h2);
    chk("d3_t1_en",   {62'd0, o3_en}, 64'd0);
    drive(2'b00, 9, 0, 32'h3, 0); tick();
    chk("d3_t2_en",   {62'd0, o3_en}, 64'd1);
    chk("d3_t2_out",  o3_data, 64'h1);
    chk("d3_t2_qd",   o3_qd, 64'h2);
    tick();
    chk("d3_t3_out",  o3_data, 64'h2);
    chk("d3_t3_qd",   o3_qd, 64'h2);
    tick();
    chk("d3_t4_hit",  {62'd0, o3_hit}, 64'd0);
    chk("d3_t4_qd",   o3_qd, 64'h0);
    chk("d3_t4_cnt",  {32'd0, o3_cnt}, 64'd2);

    // Reset with three bundles in flight and stall asserted.
    drive(2'b11, 1, 2, 32'h5, 32'h6);
    q_addr = {5'd2, 5'd1};
    tick(); tick(); tick(); tick();
    chk("d3_fill_en",  {62'd0, o3_en}, 64'd3);
    chk("d3_fill_cnt", {32'd0, o3_cnt}, 64'd4);
    chk("d3_fill_hit", {62'd0, o3_hit}, 64'd3);
    rst = 1'b1; stall = 1'b1; tick();
    chk("d3_rst_en",   {62'd0, o3_en}, 64'd0);
    chk("d3_rst_data", o3_data, 64'd0);
    chk("d3_rst_addr", {54'd0, o3_addr}, 64'd0);
    chk("d3_rst_hit",  {62'd0, o3_hit}, 64'd0);
    chk("d3_rst_qd",   o3_qd, 64'd0);
    chk("d3_rst_cnt",  {32'd0, o3_cnt}, 64'd0);
    rst = 1'b0; stall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
